// File: rtl/aes_pkg.sv
// Shared Rijndael helpers: byte type, legal block widths, row offsets and byte indexing.
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam int NB_LEGAL [3] = '{4, 6, 8};

  function automatic bit nb_is_legal(input int nb);
    return (nb == NB_LEGAL[0]) || (nb == NB_LEGAL[1]) || (nb == NB_LEGAL[2]);
  endfunction

  // Row rotation amount; the 256-bit block skips offset 2 on the lower rows.
  function automatic int rot_offset(input int nb, input int row);
    int off;
    if ((nb == 8) && (row >= 2)) begin
      off = row + 1;
    end else begin
      off = row;
    end
    return off;
  endfunction

  function automatic int byte_idx(input int row, input int col);
    return row + 4 * col;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for an NB-column state.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] stateIn,
  input  logic             inv,
  output logic [32*NB-1:0] stateOut
);

  localparam int W = 32 * NB;

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int S   = rot_offset(NB, r);
      localparam int FC  = (c + S) % NB;
      localparam int IC  = (c + NB - S) % NB;
      localparam int DST = W - 1 - 8 * byte_idx(r, c);
      localparam int FSR = W - 1 - 8 * byte_idx(r, FC);
      localparam int ISR = W - 1 - 8 * byte_idx(r, IC);

      byte_t fwd_b;
      byte_t inv_b;

      assign fwd_b = stateIn[FSR -: 8];
      assign inv_b = stateIn[ISR -: 8];
      assign stateOut[DST -: 8] = inv ? inv_b : fwd_b;
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// One-stage valid/ready ShiftRows/InvShiftRows pipeline register.
// Define SHIFT_ROWS_PIPE_SKID_EN to add a skid register and a registered in_ready.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [32*NB-1:0] stateIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [32*NB-1:0] stateOut
);

  localparam int W = 32 * NB;

  localparam logic [1:0] EMPTY     = 2'd0;
  localparam logic [1:0] FULL      = 2'd1;
`ifdef SHIFT_ROWS_PIPE_SKID_EN
  localparam logic [1:0] FULL_SKID = 2'd2;
`endif

  if (!nb_is_legal(NB)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  logic [W-1:0]     perm_s;
  logic [1:0]       state_r;
  logic [1:0]       state_nxt;
  logic             in_xfer;
  logic             out_xfer;
  logic             load_out;
  logic [W-1:0]     data_r;
  logic [TAG_W-1:0] tag_r;

  shift_rows_perm #(.NB(NB)) u_perm (
    .stateIn (stateIn),
    .inv     (in_inv),
    .stateOut(perm_s)
  );

  assign out_valid = (state_r != EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign stateOut  = data_r;
  assign out_tag   = tag_r;

`ifdef SHIFT_ROWS_PIPE_SKID_EN
  logic             load_skid;
  logic             promote;
  logic             in_ready_r;
  logic [W-1:0]     skid_data_r;
  logic [TAG_W-1:0] skid_tag_r;

  assign in_ready = in_ready_r;
`else
  logic run_r;

  // in_ready stays low through reset and rises on the first clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  assign in_ready = run_r & ((state_r == EMPTY) | out_ready);
`endif

  // Next-state and register-load decode for the output stage.
  always_comb begin
    state_nxt = state_r;
    load_out  = 1'b0;
`ifdef SHIFT_ROWS_PIPE_SKID_EN
    load_skid = 1'b0;
    promote   = 1'b0;
`endif
    case (state_r)
      EMPTY: begin
        if (in_xfer) begin
          load_out  = 1'b1;
          state_nxt = FULL;
        end else begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          load_out  = in_xfer;
          state_nxt = in_xfer ? FULL : EMPTY;
        end else begin
`ifdef SHIFT_ROWS_PIPE_SKID_EN
          load_skid = in_xfer;
          state_nxt = in_xfer ? FULL_SKID : FULL;
`else
          state_nxt = FULL;
`endif
        end
      end
`ifdef SHIFT_ROWS_PIPE_SKID_EN
      FULL_SKID: begin
        if (out_xfer) begin
          promote   = 1'b1;
          state_nxt = FULL;
        end else begin
          state_nxt = FULL_SKID;
        end
      end
`endif
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Output data and tag register; held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= {W{1'b0}};
      tag_r  <= {TAG_W{1'b0}};
    end else if (load_out) begin
      data_r <= perm_s;
      tag_r  <= in_tag;
`ifdef SHIFT_ROWS_PIPE_SKID_EN
    end else if (promote) begin
      data_r <= skid_data_r;
      tag_r  <= skid_tag_r;
`endif
    end
  end

`ifdef SHIFT_ROWS_PIPE_SKID_EN
  // Skid register and registered in_ready, so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data_r <= {W{1'b0}};
      skid_tag_r  <= {TAG_W{1'b0}};
      in_ready_r  <= 1'b0;
    end else begin
      if (load_skid) begin
        skid_data_r <= perm_s;
        skid_tag_r  <= in_tag;
      end
      in_ready_r <= (state_nxt != FULL_SKID);
    end
  end
`endif

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised, registered Rijndael ShiftRows/InvShiftRows engine for the cipher datapath, sitting between SubBytes and MixColumns in either direction.
- Supports Rijndael block widths Nb = 4/6/8 columns and selects direction per transaction.
- Uses a valid/ready handshake with one register stage and an optional skid buffer, so it composes into the pipelined round loop.

Parameters:
- NB, default 4: state columns (legal values 4, 6, 8); the state width is 32*NB bits.
- TAG_W, default 4: width of the sideband tag carried alongside each state.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input state is valid.
- in_ready  out  1  block accepts input this cycle.
- in_inv  in  1  direction: 0 = ShiftRows, 1 = InvShiftRows.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- stateIn  in  32*NB  input state.
- out_valid  out  1  output state is valid.
- out_ready  in  1  downstream accepts output.
- out_tag  out  TAG_W  tag of the output state.
- stateOut  out  32*NB  shifted state.

Behaviour:
- Byte map: byte index i = r + 4c (row r 0..3, column c 0..NB-1) occupies bits [32*NB-1-8i -: 8], so byte 0 is in the MSBs (column-major, FIPS-197 order).
- Row offsets s(r):
  - NB=4 or NB=6: 0, 1, 2, 3.
  - NB=8: 0, 1, 3, 4.
- Forward: out[r][c] = in[r][(c + s(r)) mod NB].
- Inverse: out[r][c] = in[r][(c - s(r)) mod NB].
- The shift is combinational. The result, together with the tag, is captured into the output register on an input transfer (in_valid && in_ready).
- Latency is 1 cycle from input transfer to out_valid, with throughput of 1 state per cycle while out_ready is held high.
- Output FSM without the skid buffer:
  - EMPTY: in_ready = 1; an input transfer moves to FULL.
  - FULL: out_valid = 1; in_ready = out_ready.
  - In FULL, a simultaneous output and input transfer loads the new state and stays in FULL.
  - In FULL, an output transfer with no input transfer moves to EMPTY.
  - In FULL, out_ready = 0 holds stateOut and out_tag stable.
- Output data and tag are stable while out_valid && !out_ready. in_inv, in_tag and stateIn are sampled only on the transfer cycle.
- Reset (asynchronous, at any time, including mid-stall):
  - State returns to EMPTY; out_valid = 0; in_ready = 0 while rst_n is low.
  - stateOut = 0 and out_tag = 0; any in-flight state is discarded.
  - in_ready rises in the first cycle after rst_n deasserts.
- in_valid while in_ready = 0: no transfer; the upstream must hold its data.
- Illegal NB (any value other than 4, 6, 8): elaboration-time $error.

Optional Feature:
- Macro: SHIFT_ROWS_PIPE_SKID_EN.
- When defined:
  - A second register (skid) is added, and in_ready becomes a registered signal driven as !skid_full.
  - FSM states are EMPTY, FULL and FULL_SKID.
  - In FULL with out_ready = 0, an input transfer goes to the skid register and the FSM moves to FULL_SKID (in_ready = 0).
  - In FULL_SKID, an output transfer promotes the skid contents to the output register and the FSM moves to FULL.
  - Order is preserved, and no combinational path exists from out_ready to in_ready.
- When not defined: the single-register behaviour above, where in_ready depends combinationally on out_ready in FULL.

Decomposition:
- Shared package aes_pkg:
  - byte_t typedef.
  - Function rot_offset(nb, row).
  - Function byte_idx(row, col).
  - Localparam list of legal NB values.
- One sub-module, shift_rows_perm: purely combinational, parametrised on NB; inputs stateIn and inv, output the permuted state. It is reused by the key-schedule test model.
- shift_rows_pipe contains only the handshake FSM, the registers and the optional skid buffer.

Test Plan:
- FIPS-197 forward, NB=4, inv=0:
  - Stimulus: stateIn = d42711aee0bf98f1b8b45de51e415230, tag 5.
  - Response: one cycle later stateOut = d4bf5d30e0b452aeb84111f11e2798e5, out_tag = 5.
- Inverse round-trip, NB=4, inv=1:
  - Stimulus: stateIn = d4bf5d30e0b452aeb84111f11e2798e5.
  - Response: stateOut = d42711aee0bf98f1b8b45de51e415230.
- NB=8 offsets:
  - Stimulus: state bytes 00..1f (byte i = i).
  - Response: row 3, column 0 output = byte (3 + 4*4) = 0x13; row 2, column 0 = 0x0e; forward followed by inverse returns the identity.
- Back-pressure:
  - Stimulus: stream 8 states with out_ready toggling 1,0,0,1 repeatedly.
  - Response: all 8 outputs in order with no loss or duplication; stateOut stable during stalls. With SKID_EN, in_ready never depends combinationally on out_ready (checked by assertion).
- Reset mid-operation:
  - Stimulus: assert rst_n low asynchronously while out_valid = 1 and out_ready = 0.
  - Response: out_valid, stateOut and out_tag go to 0 immediately; first cycle after release in_ready = 1; the stalled state is never emitted.
- Random stress, NB in {4, 6, 8}:
  - Stimulus: 10k random states, directions and handshake patterns.
  - Response: output matches the scoreboard reference model and tags stay aligned with their data.
